// File: rtl/peripheral_pkg.sv
// Shared definitions for the board peripherals.
//   putresult_state_t : readout FSM states (IDLE, SHOW, DONE)
//   PERIPH_BYTE_W     : width of one displayed byte
//   PERIPH_POS_W      : width of the displayed-byte index
package peripheral_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } putresult_state_t;

    localparam int unsigned PERIPH_BYTE_W = 8;
    localparam int unsigned PERIPH_POS_W  = 4;

endpackage

// File: rtl/peripheral_edgedetect.sv
// Push-button rising-edge detector.
// A 2-flop synchronizer brings the raw button level into the clk domain; a
// registered edge detector then emits a single-cycle pulse per rising edge.
// A rise first sampled at edge N gives rise=1 for the cycle after edge N+2.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset; all flops clear to 0
//   din   : raw (debounced upstream) button level, asynchronous to clk
//   rise  : one-cycle pulse per rising edge of din
module peripheral_edgedetect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic sync1_q, sync2_q, prev_q, rise_q;
    logic rise_d;

    assign rise_d = sync2_q & ~prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/peripheral_putresult.sv
// Result readout peripheral.
// Captures an ALU result on a one-cycle valid strobe and presents it one byte
// at a time; each button press advances to the next byte. After the last
// byte a further press enters DONE, and one more press returns to IDLE.
// Build option: define PUTRESULT_MSB_FIRST_EN to show the most significant
// byte first (pos=k displays byte NBYTES-1-k).
// Ports:
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   result_valid : one-cycle strobe, dataR valid in the same cycle
//   dataR        : result word, 8*NBYTES bits
//   nextpulse    : raw button level, asynchronous to clk
//   result_ready : high in IDLE
//   dataoutput   : byte currently displayed
//   pos          : index of displayed byte, 0..NBYTES-1
//   busy         : high in SHOW
//   done         : high in DONE
module peripheral_putresult
    import peripheral_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              result_valid,
    input  logic [PERIPH_BYTE_W*NBYTES-1:0]   dataR,
    input  logic                              nextpulse,
    output logic                              result_ready,
    output logic [PERIPH_BYTE_W-1:0]          dataoutput,
    output logic [PERIPH_POS_W-1:0]           pos,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned RES_W = PERIPH_BYTE_W * NBYTES;
    localparam logic [PERIPH_POS_W-1:0] LAST_POS = PERIPH_POS_W'(NBYTES - 1);

    putresult_state_t              state_q, state_d;
    logic [RES_W-1:0]              result_q, result_d;
    logic [PERIPH_POS_W-1:0]       pos_q, pos_d;
    logic [PERIPH_BYTE_W-1:0]      dout_q, dout_d;
    logic                          step;
    logic                          capture;

    // Byte shown at display position p, honouring the readout order.
    function automatic logic [PERIPH_BYTE_W-1:0] byte_at(
        input logic [RES_W-1:0]        word,
        input logic [PERIPH_POS_W-1:0] p
    );
        logic [PERIPH_BYTE_W-1:0] b;
        b = '0;
        for (int k = 0; k < int'(NBYTES); k++) begin
`ifdef PUTRESULT_MSB_FIRST_EN
            if (int'(p) == int'(NBYTES) - 1 - k) b = word[k*PERIPH_BYTE_W +: PERIPH_BYTE_W];
`else
            if (int'(p) == k) b = word[k*PERIPH_BYTE_W +: PERIPH_BYTE_W];
`endif
        end
        return b;
    endfunction

    peripheral_edgedetect u_edgedetect (
        .clk   (clk),
        .reset (reset),
        .din   (nextpulse),
        .rise  (step)
    );

    // A new result is accepted in IDLE and DONE; in DONE it takes priority over step.
    assign capture = result_valid && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        pos_d    = pos_q;
        dout_d   = dout_q;
        if (capture) begin
            state_d  = SHOW;
            result_d = dataR;
            pos_d    = '0;
            dout_d   = byte_at(dataR, '0);
        end else begin
            unique case (state_q)
                IDLE: ;
                SHOW: begin
                    if (step) begin
                        if (pos_q < LAST_POS) begin
                            pos_d  = pos_q + 1'b1;
                            dout_d = byte_at(result_q, pos_q + 1'b1);
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (step) begin
                        state_d = IDLE;
                        pos_d   = '0;
                        dout_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    pos_d   = '0;
                    dout_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            pos_q    <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            pos_q    <= pos_d;
            dout_q   <= dout_d;
        end
    end

    assign result_ready = (state_q == IDLE);
    assign busy         = (state_q == SHOW);
    assign done         = (state_q == DONE);
    assign dataoutput   = dout_q;
    assign pos          = pos_q;

endmodule

// File: tb/tb_peripheral_putresult.sv
module tb_peripheral_putresult;

    localparam int NB = 4;

`ifdef PUTRESULT_MSB_FIRST_EN
    localparam logic [7:0] E0 = 8'hDE, E1 = 8'hAD, E2 = 8'hBE, E3 = 8'hEF;
    localparam logic [7:0] A5_FIRST = 8'h00;
`else
    localparam logic [7:0] E0 = 8'hEF, E1 = 8'hBE, E2 = 8'hAD, E3 = 8'hDE;
    localparam logic [7:0] A5_FIRST = 8'hA5;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        result_valid = 1'b0;
    logic [31:0] dataR = '0;
    logic        nextpulse = 1'b0;
    logic        result_ready;
    logic [7:0]  dataoutput;
    logic [3:0]  pos;
    logic        busy;
    logic        done;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;
    int hold = 0;

    peripheral_putresult #(.NBYTES(NB)) dut (
        .clk          (clk),
        .reset        (reset),
        .result_valid (result_valid),
        .dataR        (dataR),
        .nextpulse    (nextpulse),
        .result_ready (result_ready),
        .dataoutput   (dataoutput),
        .pos          (pos),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: mode 0=idle 1=show 2=done; button samples delayed in a history line.
    int          mst;
    int          mpos;
    logic [31:0] mres;
    logic [3:0]  hist;
    wire         mstep = hist[2] & ~hist[3];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mst <= 0; mpos <= 0; mres <= '0; hist <= '0;
        end else begin
            hist <= {hist[2:0], nextpulse};
            if (result_valid && mst != 1) begin
                mst <= 1; mres <= dataR; mpos <= 0;
            end else if (mstep) begin
                if (mst == 1) begin
                    if (mpos < NB - 1) mpos <= mpos + 1;
                    else mst <= 2;
                end else if (mst == 2) begin
                    mst <= 0; mpos <= 0;
                end
            end
        end
    end

    function automatic logic [7:0] model_byte();
        int idx;
`ifdef PUTRESULT_MSB_FIRST_EN
        idx = NB - 1 - mpos;
`else
        idx = mpos;
`endif
        if (mst == 0) return 8'h00;
        return 8'((mres >> (8 * idx)) & 32'hFF);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(result_ready), 32'(mst == 0));
            chk("busy", 32'(busy), 32'(mst == 1));
            chk("done", 32'(done), 32'(mst == 2));
            chk("pos", 32'(pos), 32'(mpos));
            chk("dataoutput", 32'(dataoutput), 32'(model_byte()));
        end
    end

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic capture(input logic [31:0] d);
        @(negedge clk);
        result_valid = 1'b1;
        dataR = d;
        @(negedge clk);
        result_valid = 1'b0;
        #1;
    endtask

    task automatic press();
        @(negedge clk);
        nextpulse = 1'b1;
        repeat (4) @(negedge clk);
        nextpulse = 1'b0;
        repeat (4) @(negedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst dout", 32'(dataoutput), 32'h00);
        chk("rst pos", 32'(pos), 32'h0);
        chk("rst ready", 32'(result_ready), 32'h1);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        reset = 1'b1;
        chk_en = 1'b1;

        capture(32'hDEADBEEF);
        chk("cap dout", 32'(dataoutput), 32'(E0));
        chk("cap pos", 32'(pos), 32'h0);
        chk("cap ready", 32'(result_ready), 32'h0);
        press();
        chk("p1 dout", 32'(dataoutput), 32'(E1));
        chk("p1 pos", 32'(pos), 32'h1);
        capture(32'h12345678);
        chk("ignore dout", 32'(dataoutput), 32'(E1));
        chk("ignore pos", 32'(pos), 32'h1);
        press();
        chk("p2 dout", 32'(dataoutput), 32'(E2));
        press();
        chk("p3 dout", 32'(dataoutput), 32'(E3));
        chk("p3 pos", 32'(pos), 32'h3);
        press();
        chk("p4 done", 32'(done), 32'h1);
        chk("p4 dout", 32'(dataoutput), 32'(E3));
        chk("p4 pos", 32'(pos), 32'h3);
        press();
        chk("p5 ready", 32'(result_ready), 32'h1);
        chk("p5 dout", 32'(dataoutput), 32'h00);

        // Held button: exactly one advance, three edges after the rise.
        capture(32'hDEADBEEF);
        @(negedge clk);
        nextpulse = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("held early pos", 32'(pos), 32'h0);
        @(negedge clk);
        #1 chk("held step pos", 32'(pos), 32'h1);
        repeat (46) @(negedge clk);
        nextpulse = 1'b0;
        repeat (5) @(negedge clk);
        #1 chk("held final pos", 32'(pos), 32'h1);
        chk("held final dout", 32'(dataoutput), 32'(E1));

        press();
        press();
        press();
        chk("pre-collide done", 32'(done), 32'h1);
        // Step lands on the same edge as result_valid.
        @(negedge clk);
        nextpulse = 1'b1;
        repeat (3) @(negedge clk);
        result_valid = 1'b1;
        dataR = 32'h0000_00A5;
        @(negedge clk);
        result_valid = 1'b0;
        #1;
        chk("collide busy", 32'(busy), 32'h1);
        chk("collide pos", 32'(pos), 32'h0);
        chk("collide dout", 32'(dataoutput), 32'(A5_FIRST));
        nextpulse = 1'b0;
        repeat (5) @(negedge clk);
        #1 chk("after collide pos", 32'(pos), 32'h0);
        #1 reset = 1'b0;
        #1;
        chk("midrst ready", 32'(result_ready), 32'h1);
        chk("midrst busy", 32'(busy), 32'h0);
        chk("midrst done", 32'(done), 32'h0);
        chk("midrst pos", 32'(pos), 32'h0);
        chk("midrst dout", 32'(dataoutput), 32'h00);
        #1 reset = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            result_valid = ($urandom_range(7) == 0);
            dataR = $urandom;
            if (hold == 0) begin
                nextpulse = ~nextpulse;
                hold = $urandom_range(8, 2);
            end else begin
                hold--;
            end
            if ($urandom_range(499) == 0) begin
                #2 reset = 1'b0;
                #1 reset = 1'b1;
            end
        end
        result_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
